// File: rtl/vfifo_pkg.sv
// vfifo_pkg: shared FIFO constants, pointer width helper, and wrap-bit full/empty compares.
package vfifo_pkg;
  localparam int OUT_DEPTH = 2;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_MAX = 32;
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
  function automatic logic ptr_empty(input logic [PTR_MAX-1:0] wp, input logic [PTR_MAX-1:0] rp);
    return wp == rp;
  endfunction
  function automatic logic ptr_full(input logic [PTR_MAX-1:0] wp, input logic [PTR_MAX-1:0] rp, input int aw);
    return (wp ^ rp) == (PTR_MAX'(1) << aw);
  endfunction
endpackage

// File: rtl/vfifo_out_buf.sv
// vfifo_out_buf: 2-entry main/skid pop buffer (in: clk rst load load_dat pop; out: m_valid m_dat out_cnt).
module vfifo_out_buf import vfifo_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_dat,
  input  logic                  pop,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_dat,
  output logic [CNT_W-1:0]      out_cnt
);
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic [CNT_W-1:0] cnt_sh;
  assign cnt_sh = out_cnt - CNT_W'(pop);
  assign m_valid = !rst && out_cnt != '0;
  assign m_dat = rst ? '0 : main_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      out_cnt <= cnt_sh + CNT_W'(load);
      main_q <= load && cnt_sh == '0 ? load_dat : pop ? skid_q : main_q;
      skid_q <= load && cnt_sh != '0 ? load_dat : skid_q;
    end
  end
endmodule

// File: rtl/vfifo_sc_ctrl.sv
// vfifo_sc_ctrl: single-clock FWFT FIFO controller (push s_*, pop m_*, count; drives RAM port A write / port B read).
module vfifo_sc_ctrl import vfifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_dat,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);
  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam int LW = CNT_W + 1;
  localparam int CW = ADDR_WIDTH + 2;
  logic [PW-1:0] wr_ptr, rd_ptr, ptr_diff;
  logic rd_pend, ram_empty, ram_full, push, pop, issue;
  logic [CNT_W-1:0] out_cnt;
  logic [LW-1:0] lvl;
  assign ram_empty = ptr_empty(PTR_MAX'(wr_ptr), PTR_MAX'(rd_ptr));
  assign ram_full = ptr_full(PTR_MAX'(wr_ptr), PTR_MAX'(rd_ptr), ADDR_WIDTH);
  assign s_ready = !ram_full && !rst;
  assign push = s_valid && s_ready;
  assign pop = m_valid && m_ready;
  assign lvl = LW'(out_cnt) + LW'(rd_pend) - LW'(pop);
  assign issue = !ram_empty && lvl < LW'(OUT_DEPTH);
  assign ram_adr_a = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_d_a = s_dat;
  assign ram_we_a = push;
  assign ram_adr_b = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_we_b = 1'b0;
  assign ptr_diff = wr_ptr - rd_ptr;
  assign count = rst ? '0 : CW'(ptr_diff) + CW'(rd_pend) + CW'(out_cnt);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_pend <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(issue);
      rd_pend <= issue;
    end
  end
  vfifo_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk(clk),
    .rst(rst),
    .load(rd_pend),
    .load_dat(ram_q_b),
    .pop(pop),
    .m_valid(m_valid),
    .m_dat(m_dat),
    .out_cnt(out_cnt)
  );
endmodule

// File: tb/tb_vfifo_sc_ctrl.sv
// tb_vfifo_sc_ctrl: directed self-checking bench for vfifo_sc_ctrl with a behavioural registered-read RAM.
module tb_vfifo_sc_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] s_dat = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [DW-1:0] m_dat;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_adr_a, ram_adr_b;
  logic [DW-1:0] ram_d_a, ram_q_b;
  logic ram_we_a, ram_we_b;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] exp_q [$];
  logic pushed, popped;
  logic [DW-1:0] got;
  int checks = 0;
  int errors = 0;

  vfifo_sc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .m_dat(m_dat), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .ram_adr_a(ram_adr_a), .ram_d_a(ram_d_a), .ram_we_a(ram_we_a),
    .ram_adr_b(ram_adr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    ram_q_b <= mem[ram_adr_b];
  end

  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr);
    @(negedge clk);
    s_valid = sv;
    s_dat = sd;
    m_ready = mr;
    #1;
    pushed = s_valid && s_ready;
    popped = m_valid && m_ready;
    got = m_dat;
    if (pushed) exp_q.push_back(s_dat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 8'h11, 1'b1);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
    checks++; if (ram_we_a !== 1'b0) begin errors++; $display("FAIL rst_we_a got %b exp 0", ram_we_a); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
    checks++; if (count !== 0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (m_dat !== 8'h00) begin errors++; $display("FAIL rst_m_dat got %h exp 00", m_dat); end
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] e;
    step(1'b1, 8'hA5, 1'b0);
    checks++; if (pushed !== 1'b1) begin errors++; $display("FAIL single_push got %b exp 1", pushed); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (count !== 1) begin errors++; $display("FAIL single_count_e0 got %0d exp 1", count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e0 got %b exp 0", m_valid); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e1 got %b exp 0", m_valid); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e2 got %b exp 1", m_valid); end
    checks++; if (m_dat !== 8'hA5) begin errors++; $display("FAIL single_dat got %h exp a5", m_dat); end
    checks++; if (count !== 1) begin errors++; $display("FAIL single_count_e2 got %0d exp 1", count); end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    if (!popped || got !== e) begin errors++; $display("FAIL single_pop got %h/%b exp %h/1", got, popped, e); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (count !== 0) begin errors++; $display("FAIL single_count_end got %0d exp 0", count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_end got %b exp 0", m_valid); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] e;
    int np = 0, nr = 0, first = -1, last = -1;
    for (int c = 0; c < 80 && nr < 40; c++) begin
      step(np < 40, DW'(np), 1'b1);
      if (pushed) np++;
      if (popped) begin
        checks++;
        e = DW'(nr);
        if (got !== e) begin errors++; $display("FAIL stream_data got %h exp %h", got, e); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (first < 0) first = c;
        last = c;
        nr++;
      end
    end
    checks++; if (nr !== 40) begin errors++; $display("FAIL stream_words got %0d exp 40", nr); end
    checks++; if (first !== 3) begin errors++; $display("FAIL stream_latency got %0d exp 3", first); end
    checks++; if (last !== 42) begin errors++; $display("FAIL stream_last got %0d exp 42", last); end
  endtask

  task automatic test_full();
    logic [DW-1:0] e;
    logic seen = 1'b0;
    int np = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DW'(8'h10 + i), 1'b0);
      if (pushed) np++;
    end
    checks++; if (np !== 10) begin errors++; $display("FAIL full_pushes got %0d exp 10", np); end
    checks++; if (count !== 10) begin errors++; $display("FAIL full_count got %0d exp 10", count); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got %b exp 0", s_ready); end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    if (!popped || got !== e) begin errors++; $display("FAIL full_first_pop got %h/%b exp %h/1", got, popped, e); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (s_ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL full_ready_return got %b exp 1", seen); end
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      step(1'b0, 8'h00, 1'b1);
      if (popped) begin
        checks++;
        e = exp_q.pop_front();
        if (got !== e) begin errors++; $display("FAIL full_drain got %h exp %h", got, e); end
      end
    end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (exp_q.size() !== 0 || count !== 0) begin errors++; $display("FAIL full_drained got count %0d left %0d exp 0 0", count, exp_q.size()); end
  endtask

  task automatic test_random();
    logic [DW-1:0] e;
    int np = 0, nr = 0, mc = 0;
    for (int c = 0; c < 20000 && nr < 2000; c++) begin
      step(np < 2000 && $urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 3) != 0);
      checks++; if (count !== (AW+2)'(mc)) begin errors++; $display("FAIL rand_count got %0d exp %0d", count, mc); end
      checks++; if (ram_we_b !== 1'b0 || ram_d_a !== s_dat) begin errors++; $display("FAIL rand_ram_port got we_b %b d_a %h exp 0 %h", ram_we_b, ram_d_a, s_dat); end
      if (pushed) begin np++; mc++; end
      if (popped) begin
        checks++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (got !== e) begin errors++; $display("FAIL rand_data got %h exp %h", got, e); end
        nr++;
        mc--;
      end
    end
    checks++; if (nr !== 2000) begin errors++; $display("FAIL rand_words got %0d exp 2000", nr); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] e;
    int nr = 0;
    for (int i = 0; i < 6; i++) step(1'b1, DW'(8'h50 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    checks++; if (popped !== 1'b1 || got !== 8'h50) begin errors++; $display("FAIL mid_pop got %h/%b exp 50/1", got, popped); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (count !== 5) begin errors++; $display("FAIL mid_count_before got %0d exp 5", count); end
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    checks++; if (m_valid !== 1'b0 || count !== 0 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs got valid %b count %0d ready %b exp 0 0 0", m_valid, count, s_ready); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (m_valid !== 1'b0 || count !== 0 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got valid %b count %0d ready %b exp 0 0 0", m_valid, count, s_ready); end
    exp_q.delete();
    rst = 1'b0;
    step(1'b1, 8'h3C, 1'b1);
    checks++; if (m_valid !== 1'b0 || count !== 0) begin errors++; $display("FAIL mid_after_rst got valid %b count %0d exp 0 0", m_valid, count); end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 8'h00, 1'b1);
      if (popped) begin
        checks++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (got !== e) begin errors++; $display("FAIL mid_stale got %h exp %h", got, e); end
        nr++;
      end
    end
    checks++; if (nr !== 1 || count !== 0) begin errors++; $display("FAIL mid_words got %0d count %0d exp 1 0", nr, count); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h80 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    checks++; if (count !== 4) begin errors++; $display("FAIL b2b_count_start got %0d exp 4", count); end
    for (int i = 0; i < 50; i++) begin
      step(1'b1, DW'(8'hC0 + i), 1'b1);
      checks++; if (count !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", count); end
      checks++; if (!(pushed && popped)) begin errors++; $display("FAIL b2b_both got push %b pop %b exp 1 1", pushed, popped); end
      if (popped) begin
        checks++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (got !== e) begin errors++; $display("FAIL b2b_data got %h exp %h", got, e); end
      end
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step(1'b0, 8'h00, 1'b1);
      if (popped) begin
        checks++;
        e = exp_q.pop_front();
        if (got !== e) begin errors++; $display("FAIL b2b_drain got %h exp %h", got, e); end
      end
    end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (exp_q.size() !== 0 || count !== 0) begin errors++; $display("FAIL b2b_drained got count %0d left %0d exp 0 0", count, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_full();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
